// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// nibble width, controller states and the slice carry-out reconstruction.
package nibble_serial_addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The slice exposes only sum and signed overflow; recover the unsigned carry
  // out of its MSB from the operand and result sign bits.
  function automatic logic nibble_carry(input logic [NIBBLE_W-1:0] a,
                                        input logic [NIBBLE_W-1:0] b,
                                        input logic [NIBBLE_W-1:0] r);
    return (a[NIBBLE_W-1] & b[NIBBLE_W-1]) |
           ((a[NIBBLE_W-1] ^ b[NIBBLE_W-1]) & ~r[NIBBLE_W-1]);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub.sv
// Wide signed add/subtract performed one nibble per cycle through an external
// combinational 4-bit adder slice, with valid/ready operand and result ports.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W      = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_a,
  input  logic [W-1:0]        in_b,
  input  logic                in_op,
  output logic [NIBBLE_W-1:0] slice_a,
  output logic [NIBBLE_W-1:0] slice_b,
  output logic                slice_cin,
  input  logic [NIBBLE_W-1:0] slice_result,
  input  logic                slice_ovf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_sum,
  output logic                out_overflow,
  output logic                out_carry,
  output logic                out_zero
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and DONE holds every output until taken.

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic ovf_q, ovf_d, cout_q, cout_d;
  logic accept, last, nib_carry;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last      = (idx_q == LAST_IDX);
  assign nib_carry = nibble_carry(slice_a, slice_b, slice_result);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        slice_a   = a_q[idx_q];
        slice_b   = b_q[idx_q];
        slice_cin = carry_q;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted on capture and the +1 enters as carry.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = in_a;
      b_d     = in_op ? ~in_b : in_b;
      carry_d = in_op;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      sum_d[idx_q] = slice_result;
      carry_d      = nib_carry;
      idx_d        = idx_q + IDX_W'(1);
      if (last) begin
        ovf_d  = slice_ovf;
        cout_d = nib_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
    end
  end

  assign out_sum      = sum_q;
  assign out_overflow = ovf_q;
  assign out_carry    = cout_q;
  assign out_zero     = (sum_q == '0);

endmodule
